// File: rtl/load_queue.sv
// load_queue: circular buffer of in-flight loads.
// Each entry moves FREE -> WAIT_ADDR -> READY -> ISSUED -> DONE -> SENT -> FREE.
// Up to two loads are dispatched per cycle at the tail, and loads retire at the head.
// Build macro LQ_OOO_ISSUE_EN: when defined, the oldest READY entry issues.
// When undefined, only the head entry may issue.
//
// Handshakes (valid/ready): a request or broadcast shown with valid=1 keeps the
// same payload and index on every cycle until the consumer accepts it
// (lq_mem_req_ready / lq_cdb_grant). A transfer happens on a clock edge where
// valid and accept are both high. Only flush or reset withdraws a shown valid.
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif

module load_queue #(
   parameter int LQ_SIZE  = 8,
   parameter int ROB_SIZE = `ROB_SIZE,
   parameter int PRF_SIZE = `PRF_SIZE,
   localparam int RW = $clog2(ROB_SIZE) + 1,
   localparam int PW = $clog2(PRF_SIZE),
   localparam int QW = $clog2(LQ_SIZE)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          lq_mem_in1,
   input  logic          lq_mem_in2,
   input  logic [63:0]   lq_opa_in1,
   input  logic [63:0]   lq_opa_in2,
   input  logic [63:0]   lq_opb_in1,
   input  logic [63:0]   lq_opb_in2,
   input  logic          lq_opb_valid1,
   input  logic          lq_opb_valid2,
   input  logic [RW-1:0] lq_rob_idx_in1,
   input  logic [RW-1:0] lq_rob_idx_in2,
   input  logic [PW-1:0] lq_dest_idx1,
   input  logic [PW-1:0] lq_dest_idx2,
   input  logic [63:0]   cdb1_in,
   input  logic [63:0]   cdb2_in,
   input  logic [PW-1:0] cdb1_tag,
   input  logic [PW-1:0] cdb2_tag,
   input  logic          cdb1_valid,
   input  logic          cdb2_valid,
   input  logic          lq_commit,
   input  logic          lq_flush,
   output logic          lq_mem_req_valid,
   output logic [63:0]   lq_mem_req_addr,
   output logic [QW-1:0] lq_mem_req_tag,
   input  logic          lq_mem_req_ready,
   input  logic          lq_mem_resp_valid,
   input  logic [QW-1:0] lq_mem_resp_tag,
   input  logic [63:0]   lq_mem_resp_data,
   output logic          lq_cdb_valid,
   output logic [63:0]   lq_cdb_data,
   output logic [PW-1:0] lq_cdb_tag,
   output logic [RW-1:0] lq_cdb_rob_idx,
   input  logic          lq_cdb_grant,
   output logic          lq_full,
   output logic          lq_empty
);
   typedef enum logic [2:0] {
      S_FREE, S_WAIT_ADDR, S_READY, S_ISSUED, S_DONE, S_SENT
   } lq_state_e;

   lq_state_e     state_q [LQ_SIZE];
   lq_state_e     state_d [LQ_SIZE];
   logic [63:0]   addr_q  [LQ_SIZE];
   logic [63:0]   addr_d  [LQ_SIZE];
   logic [63:0]   opa_q   [LQ_SIZE];
   logic [63:0]   opa_d   [LQ_SIZE];
   logic [PW-1:0] wtag_q  [LQ_SIZE];
   logic [PW-1:0] wtag_d  [LQ_SIZE];
   logic [RW-1:0] rob_q   [LQ_SIZE];
   logic [RW-1:0] rob_d   [LQ_SIZE];
   logic [PW-1:0] dest_q  [LQ_SIZE];
   logic [PW-1:0] dest_d  [LQ_SIZE];
   logic [63:0]   data_q  [LQ_SIZE];
   logic [63:0]   data_d  [LQ_SIZE];

   logic [QW-1:0] head_q, head_d, tail_q, tail_d;
   logic [QW:0]   count_q, count_d;
   logic          req_lock_q, req_lock_d, cdb_lock_q, cdb_lock_d;
   logic [QW-1:0] req_idx_q, req_idx_d, cdb_idx_q, cdb_idx_d;

   logic          req_found, cdb_found;
   logic [QW-1:0] req_sel, cdb_sel, req_idx, cdb_idx, slot;
   logic [1:0]    n_alloc;
   logic          do_commit;
   logic [64:0]   hit;

   // Dispatch slots as arrays so both are handled by one loop; slot 0 is older.
   logic          dsp_v   [2];
   logic [63:0]   dsp_opa [2];
   logic [63:0]   dsp_opb [2];
   logic          dsp_bv  [2];
   logic [RW-1:0] dsp_rob [2];
   logic [PW-1:0] dsp_dest[2];

   assign dsp_v[0]    = lq_mem_in1;
   assign dsp_v[1]    = lq_mem_in2;
   assign dsp_opa[0]  = lq_opa_in1;
   assign dsp_opa[1]  = lq_opa_in2;
   assign dsp_opb[0]  = lq_opb_in1;
   assign dsp_opb[1]  = lq_opb_in2;
   assign dsp_bv[0]   = lq_opb_valid1;
   assign dsp_bv[1]   = lq_opb_valid2;
   assign dsp_rob[0]  = lq_rob_idx_in1;
   assign dsp_rob[1]  = lq_rob_idx_in2;
   assign dsp_dest[0] = lq_dest_idx1;
   assign dsp_dest[1] = lq_dest_idx2;

   // CDB snoop for one tag: returns {hit, data}; cdb1 has priority over cdb2.
   function automatic logic [64:0] cdb_lookup(input logic [PW-1:0] tag,
         input logic v1, input logic [PW-1:0] t1, input logic [63:0] d1,
         input logic v2, input logic [PW-1:0] t2, input logic [63:0] d2);
      if (v1 && t1 == tag) return {1'b1, d1};
      if (v2 && t2 == tag) return {1'b1, d2};
      return {1'b0, 64'd0};
   endfunction

   // Pick the entry that issues next and the oldest DONE entry, both searched from head.
   always_comb begin
      req_found = 1'b0;
      req_sel   = head_q;
      cdb_found = 1'b0;
      cdb_sel   = head_q;
`ifdef LQ_OOO_ISSUE_EN
      for (int i = 0; i < LQ_SIZE; i++) begin
         if (!req_found && state_q[head_q + QW'(i)] == S_READY) begin
            req_found = 1'b1;
            req_sel   = head_q + QW'(i);
         end
      end
`else
      req_found = (state_q[head_q] == S_READY);
`endif
      for (int i = 0; i < LQ_SIZE; i++) begin
         if (!cdb_found && state_q[head_q + QW'(i)] == S_DONE) begin
            cdb_found = 1'b1;
            cdb_sel   = head_q + QW'(i);
         end
      end
   end

   // A shown but unaccepted request/broadcast is locked so its payload cannot change.
   assign req_idx          = req_lock_q ? req_idx_q : req_sel;
   assign cdb_idx          = cdb_lock_q ? cdb_idx_q : cdb_sel;
   assign lq_mem_req_valid = req_lock_q | req_found;
   assign lq_mem_req_addr  = lq_mem_req_valid ? addr_q[req_idx] : '0;
   assign lq_mem_req_tag   = lq_mem_req_valid ? req_idx : '0;
   assign lq_cdb_valid     = cdb_lock_q | cdb_found;
   assign lq_cdb_data      = lq_cdb_valid ? data_q[cdb_idx] : '0;
   assign lq_cdb_tag       = lq_cdb_valid ? dest_q[cdb_idx] : '0;
   assign lq_cdb_rob_idx   = lq_cdb_valid ? rob_q[cdb_idx] : '0;
   assign lq_full          = (count_q > (QW+1)'(LQ_SIZE - 2));
   assign lq_empty         = (count_q == '0);

   // Next state of every entry and of the pointers; flush overrides everything else.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      opa_d      = opa_q;
      wtag_d     = wtag_q;
      rob_d      = rob_q;
      dest_d     = dest_q;
      data_d     = data_q;
      head_d     = head_q;
      req_lock_d = lq_mem_req_valid & ~lq_mem_req_ready;
      req_idx_d  = req_idx;
      cdb_lock_d = lq_cdb_valid & ~lq_cdb_grant;
      cdb_idx_d  = cdb_idx;
      hit        = '0;
      slot       = tail_q;
      n_alloc    = '0;

      for (int i = 0; i < LQ_SIZE; i++) begin
         if (state_q[i] == S_WAIT_ADDR) begin
            hit = cdb_lookup(wtag_q[i], cdb1_valid, cdb1_tag, cdb1_in,
                             cdb2_valid, cdb2_tag, cdb2_in);
            if (hit[64]) begin
               state_d[i] = S_READY;
               addr_d[i]  = opa_q[i] + hit[63:0];
            end
         end
      end

      if (lq_mem_req_valid && lq_mem_req_ready) state_d[req_idx] = S_ISSUED;

      if (lq_mem_resp_valid && state_q[lq_mem_resp_tag] == S_ISSUED) begin
         state_d[lq_mem_resp_tag] = S_DONE;
         data_d[lq_mem_resp_tag]  = lq_mem_resp_data;
      end

      if (lq_cdb_valid && lq_cdb_grant) state_d[cdb_idx] = S_SENT;

      do_commit = lq_commit && (state_q[head_q] == S_SENT);
      if (do_commit) begin
         state_d[head_q] = S_FREE;
         head_d          = head_q + 1'b1;
      end

      if (!lq_full) begin
         for (int s = 0; s < 2; s++) begin
            if (dsp_v[s]) begin
               hit = cdb_lookup(dsp_opb[s][PW-1:0], cdb1_valid, cdb1_tag, cdb1_in,
                                cdb2_valid, cdb2_tag, cdb2_in);
               opa_d[slot]  = dsp_opa[s];
               wtag_d[slot] = dsp_opb[s][PW-1:0];
               rob_d[slot]  = dsp_rob[s];
               dest_d[slot] = dsp_dest[s];
               if (dsp_bv[s]) begin
                  state_d[slot] = S_READY;
                  addr_d[slot]  = dsp_opa[s] + dsp_opb[s];
               end else if (hit[64]) begin
                  state_d[slot] = S_READY;
                  addr_d[slot]  = dsp_opa[s] + hit[63:0];
               end else begin
                  state_d[slot] = S_WAIT_ADDR;
               end
               slot    = slot + 1'b1;
               n_alloc = n_alloc + 2'd1;
            end
         end
      end
      tail_d  = slot;
      count_d = count_q + {{(QW-1){1'b0}}, n_alloc} - {{QW{1'b0}}, do_commit};

      if (lq_flush) begin
         for (int i = 0; i < LQ_SIZE; i++) state_d[i] = S_FREE;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         req_lock_d = 1'b0;
         cdb_lock_d = 1'b0;
      end
   end

   // Control state: entry states, pointers, occupancy and handshake locks.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < LQ_SIZE; i++) state_q[i] <= S_FREE;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         req_lock_q <= 1'b0;
         req_idx_q  <= '0;
         cdb_lock_q <= 1'b0;
         cdb_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         req_lock_q <= req_lock_d;
         req_idx_q  <= req_idx_d;
         cdb_lock_q <= cdb_lock_d;
         cdb_idx_q  <= cdb_idx_d;
      end
   end

   // Entry payload; only read while the owning state makes it meaningful.
   always_ff @(posedge clock) begin
      addr_q <= addr_d;
      opa_q  <= opa_d;
      wtag_q <= wtag_d;
      rob_q  <= rob_d;
      dest_q <= dest_d;
      data_q <= data_d;
   end
endmodule

// File: tb/tb_load_queue.sv
// Testbench for load_queue. The reference model is an age-ordered queue of
// loads. Each load records its buffer slot, and outputs are predicted from the
// age order. Directed cases run first, then randomized traffic.
`timescale 1ns/1ps
module tb_load_queue;
   localparam int LQ = 8;
   localparam int RW = 6;
   localparam int PW = 6;
   localparam int QW = 3;
   localparam int M_WAIT = 1, M_READY = 2, M_ISSUED = 3, M_DONE = 4, M_SENT = 5;

   // clock / reset
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic          lq_mem_in1, lq_mem_in2;
   logic [63:0]   lq_opa_in1, lq_opa_in2, lq_opb_in1, lq_opb_in2;
   logic          lq_opb_valid1, lq_opb_valid2;
   logic [RW-1:0] lq_rob_idx_in1, lq_rob_idx_in2;
   logic [PW-1:0] lq_dest_idx1, lq_dest_idx2;
   logic [63:0]   cdb1_in, cdb2_in;
   logic [PW-1:0] cdb1_tag, cdb2_tag;
   logic          cdb1_valid, cdb2_valid, lq_commit, lq_flush;
   logic          lq_mem_req_valid, lq_mem_req_ready;
   logic [63:0]   lq_mem_req_addr;
   logic [QW-1:0] lq_mem_req_tag;
   logic          lq_mem_resp_valid;
   logic [QW-1:0] lq_mem_resp_tag;
   logic [63:0]   lq_mem_resp_data;
   logic          lq_cdb_valid, lq_cdb_grant, lq_full, lq_empty;
   logic [63:0]   lq_cdb_data;
   logic [PW-1:0] lq_cdb_tag;
   logic [RW-1:0] lq_cdb_rob_idx;

   load_queue #(.LQ_SIZE(LQ), .ROB_SIZE(32), .PRF_SIZE(64)) dut (
      .clock(clock), .reset(reset),
      .lq_mem_in1(lq_mem_in1), .lq_mem_in2(lq_mem_in2),
      .lq_opa_in1(lq_opa_in1), .lq_opa_in2(lq_opa_in2),
      .lq_opb_in1(lq_opb_in1), .lq_opb_in2(lq_opb_in2),
      .lq_opb_valid1(lq_opb_valid1), .lq_opb_valid2(lq_opb_valid2),
      .lq_rob_idx_in1(lq_rob_idx_in1), .lq_rob_idx_in2(lq_rob_idx_in2),
      .lq_dest_idx1(lq_dest_idx1), .lq_dest_idx2(lq_dest_idx2),
      .cdb1_in(cdb1_in), .cdb2_in(cdb2_in), .cdb1_tag(cdb1_tag), .cdb2_tag(cdb2_tag),
      .cdb1_valid(cdb1_valid), .cdb2_valid(cdb2_valid),
      .lq_commit(lq_commit), .lq_flush(lq_flush),
      .lq_mem_req_valid(lq_mem_req_valid), .lq_mem_req_addr(lq_mem_req_addr),
      .lq_mem_req_tag(lq_mem_req_tag), .lq_mem_req_ready(lq_mem_req_ready),
      .lq_mem_resp_valid(lq_mem_resp_valid), .lq_mem_resp_tag(lq_mem_resp_tag),
      .lq_mem_resp_data(lq_mem_resp_data),
      .lq_cdb_valid(lq_cdb_valid), .lq_cdb_data(lq_cdb_data), .lq_cdb_tag(lq_cdb_tag),
      .lq_cdb_rob_idx(lq_cdb_rob_idx), .lq_cdb_grant(lq_cdb_grant),
      .lq_full(lq_full), .lq_empty(lq_empty)
   );

   // scoreboard state
   typedef struct {
      int            st;
      int            slot;
      logic [63:0]   opa;
      logic [63:0]   addr;
      logic [PW-1:0] tag;
      logic [RW-1:0] rob;
      logic [PW-1:0] dest;
      logic [63:0]   data;
   } ment_t;

   ment_t         mq[$];
   logic [QW-1:0] out_q[$];
   int m_tail = 0, m_rpend = -1, m_cpend = -1;
   int e_req, e_cdb;
   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int pos_of(input int slot);
      foreach (mq[i]) if (mq[i].slot == slot) return i;
      return -1;
   endfunction

   task automatic expect_outputs();
      e_req = -1;
      e_cdb = -1;
      if (m_rpend >= 0) e_req = m_rpend;
      else begin
`ifdef LQ_OOO_ISSUE_EN
         foreach (mq[i]) if (e_req < 0 && mq[i].st == M_READY) e_req = mq[i].slot;
`else
         if (mq.size() > 0 && mq[0].st == M_READY) e_req = mq[0].slot;
`endif
      end
      if (m_cpend >= 0) e_cdb = m_cpend;
      else foreach (mq[i]) if (e_cdb < 0 && mq[i].st == M_DONE) e_cdb = mq[i].slot;
   endtask

   task automatic push_entry(input logic [63:0] opa, input logic [63:0] opb, input logic bv,
                             input logic [RW-1:0] rob, input logic [PW-1:0] dest);
      ment_t e;
      e.slot = m_tail;
      m_tail = (m_tail + 1) % LQ;
      e.opa  = opa;
      e.tag  = opb[PW-1:0];
      e.rob  = rob;
      e.dest = dest;
      e.data = '0;
      e.addr = '0;
      e.st   = M_WAIT;
      if (bv) begin
         e.st = M_READY; e.addr = opa + opb;
      end else if (cdb1_valid && cdb1_tag == e.tag) begin
         e.st = M_READY; e.addr = opa + cdb1_in;
      end else if (cdb2_valid && cdb2_tag == e.tag) begin
         e.st = M_READY; e.addr = opa + cdb2_in;
      end
      mq.push_back(e);
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic update_model();
      bit full, do_commit;
      int p;
      if (!reset || lq_flush) begin
         mq.delete();
         out_q.delete();
         m_tail = 0; m_rpend = -1; m_cpend = -1;
         return;
      end
      full      = mq.size() > LQ - 2;
      do_commit = lq_commit && mq.size() > 0 && mq[0].st == M_SENT;
      foreach (mq[i]) begin
         if (mq[i].st == M_WAIT) begin
            if (cdb1_valid && cdb1_tag == mq[i].tag) begin
               mq[i].st = M_READY; mq[i].addr = mq[i].opa + cdb1_in;
            end else if (cdb2_valid && cdb2_tag == mq[i].tag) begin
               mq[i].st = M_READY; mq[i].addr = mq[i].opa + cdb2_in;
            end
         end
      end
      if (lq_mem_resp_valid) begin
         p = pos_of(int'(lq_mem_resp_tag));
         if (p >= 0 && mq[p].st == M_ISSUED) begin
            mq[p].st = M_DONE; mq[p].data = lq_mem_resp_data;
         end
      end
      if (e_req >= 0) begin
         p = pos_of(e_req);
         if (lq_mem_req_ready) begin
            mq[p].st = M_ISSUED; out_q.push_back(QW'(e_req)); m_rpend = -1;
         end else m_rpend = e_req;
      end
      if (e_cdb >= 0) begin
         p = pos_of(e_cdb);
         if (lq_cdb_grant) begin
            mq[p].st = M_SENT; m_cpend = -1;
         end else m_cpend = e_cdb;
      end
      if (do_commit) void'(mq.pop_front());
      if (!full) begin
         if (lq_mem_in1) push_entry(lq_opa_in1, lq_opb_in1, lq_opb_valid1, lq_rob_idx_in1, lq_dest_idx1);
         if (lq_mem_in2) push_entry(lq_opa_in2, lq_opb_in2, lq_opb_valid2, lq_rob_idx_in2, lq_dest_idx2);
      end
   endtask

   // Compare outputs against the model, then take one clock with the driven inputs.
   task automatic step();
      int p;
      expect_outputs();
      check("req_valid", 64'(lq_mem_req_valid), 64'(e_req >= 0));
      if (e_req >= 0) begin
         p = pos_of(e_req);
         check("req_addr", lq_mem_req_addr, mq[p].addr);
         check("req_tag", 64'(lq_mem_req_tag), 64'(e_req));
      end
      check("cdb_valid", 64'(lq_cdb_valid), 64'(e_cdb >= 0));
      if (e_cdb >= 0) begin
         p = pos_of(e_cdb);
         check("cdb_data", lq_cdb_data, mq[p].data);
         check("cdb_tag", 64'(lq_cdb_tag), 64'(mq[p].dest));
         check("cdb_rob", 64'(lq_cdb_rob_idx), 64'(mq[p].rob));
      end
      check("full", 64'(lq_full), 64'(mq.size() > LQ - 2));
      check("empty", 64'(lq_empty), 64'(mq.size() == 0));
      update_model();
      @(posedge clock);
      @(negedge clock);
   endtask

   // driver tasks
   task automatic idle();
      reset = 1'b1;
      lq_mem_in1 = 0; lq_mem_in2 = 0;
      lq_opa_in1 = '0; lq_opa_in2 = '0; lq_opb_in1 = '0; lq_opb_in2 = '0;
      lq_opb_valid1 = 0; lq_opb_valid2 = 0;
      lq_rob_idx_in1 = '0; lq_rob_idx_in2 = '0; lq_dest_idx1 = '0; lq_dest_idx2 = '0;
      cdb1_in = '0; cdb2_in = '0; cdb1_tag = '0; cdb2_tag = '0; cdb1_valid = 0; cdb2_valid = 0;
      lq_commit = 0; lq_flush = 0; lq_mem_req_ready = 0;
      lq_mem_resp_valid = 0; lq_mem_resp_tag = '0; lq_mem_resp_data = '0; lq_cdb_grant = 0;
   endtask

   task automatic dispatch1(input logic [63:0] opa, input logic [63:0] opb, input logic bv,
                            input logic [PW-1:0] dest);
      lq_mem_in1 = 1; lq_opa_in1 = opa; lq_opb_in1 = opb; lq_opb_valid1 = bv;
      lq_dest_idx1 = dest; lq_rob_idx_in1 = RW'(dest);
   endtask

   task automatic flush_all();
      idle(); lq_flush = 1; step(); idle();
   endtask

   task automatic drive_random();
      int k;
      logic [63:0] r;
      idle();
      reset         = ($urandom_range(0, 299) != 0);
      lq_flush      = ($urandom_range(0, 59) == 0);
      lq_mem_in1    = ($urandom_range(0, 2) == 0);
      lq_mem_in2    = ($urandom_range(0, 3) == 0);
      lq_opa_in1    = {$urandom, $urandom};
      lq_opa_in2    = {$urandom, $urandom};
      lq_opb_valid1 = $urandom_range(0, 1) == 1;
      lq_opb_valid2 = $urandom_range(0, 1) == 1;
      r = {$urandom, $urandom}; r[PW-1:0] = PW'($urandom_range(0, 3)); lq_opb_in1 = r;
      r = {$urandom, $urandom}; r[PW-1:0] = PW'($urandom_range(0, 3)); lq_opb_in2 = r;
      lq_rob_idx_in1 = RW'($urandom); lq_rob_idx_in2 = RW'($urandom);
      lq_dest_idx1   = PW'($urandom); lq_dest_idx2   = PW'($urandom);
      cdb1_valid = ($urandom_range(0, 2) == 0);
      cdb2_valid = ($urandom_range(0, 2) == 0);
      cdb1_tag   = PW'($urandom_range(0, 3));
      cdb2_tag   = PW'($urandom_range(0, 3));
      cdb1_in    = {$urandom, $urandom};
      cdb2_in    = {$urandom, $urandom};
      lq_mem_req_ready = $urandom_range(0, 1) == 1;
      lq_cdb_grant     = $urandom_range(0, 1) == 1;
      lq_commit        = $urandom_range(0, 1) == 1;
      if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
         k = $urandom_range(0, out_q.size() - 1);
         lq_mem_resp_valid = 1;
         lq_mem_resp_tag   = out_q[k];
         lq_mem_resp_data  = {$urandom, $urandom};
         out_q.delete(k);
      end
   endtask

   logic [63:0] a0;
   logic [QW-1:0] t0;

   initial begin
      idle();
      reset = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_req_valid", 64'(lq_mem_req_valid), 64'd0);
      check("rst_req_addr", lq_mem_req_addr, 64'd0);
      check("rst_req_tag", 64'(lq_mem_req_tag), 64'd0);
      check("rst_cdb_valid", 64'(lq_cdb_valid), 64'd0);
      check("rst_cdb_data", lq_cdb_data, 64'd0);
      check("rst_cdb_tag", 64'(lq_cdb_tag), 64'd0);
      check("rst_cdb_rob", 64'(lq_cdb_rob_idx), 64'd0);
      check("rst_full", 64'(lq_full), 64'd0);
      check("rst_empty", 64'(lq_empty), 64'd1);
      idle();
      step();

      // basic load: address add, issue, response, broadcast
      dispatch1(64'd8, 64'h1000, 1'b1, 6'd7); step(); idle();
      check("d1_req_valid", 64'(lq_mem_req_valid), 64'd1);
      check("d1_req_addr", lq_mem_req_addr, 64'h1008);
      check("d1_req_tag", 64'(lq_mem_req_tag), 64'd0);
      lq_mem_req_ready = 1; step(); idle();
      lq_mem_resp_valid = 1; lq_mem_resp_tag = '0; lq_mem_resp_data = 64'hAB; step(); idle();
      check("d1_cdb_valid", 64'(lq_cdb_valid), 64'd1);
      check("d1_cdb_data", lq_cdb_data, 64'hAB);
      check("d1_cdb_tag", 64'(lq_cdb_tag), 64'd7);
      lq_cdb_grant = 1; step(); idle();
      lq_commit = 1; step(); idle();
      check("d1_empty", 64'(lq_empty), 64'd1);
      flush_all();

      // both CDBs match a waiting base: cdb1 wins
      dispatch1(64'h100, 64'd5, 1'b0, 6'd1); step(); idle();
      cdb1_valid = 1; cdb1_tag = 6'd5; cdb1_in = 64'h10;
      cdb2_valid = 1; cdb2_tag = 6'd5; cdb2_in = 64'h20;
      step(); idle();
      check("cdb_prio_addr", lq_mem_req_addr, 64'h110);
      flush_all();

      // full threshold and ignored dispatch
      for (int i = 0; i < 7; i++) begin
         if (i == 6) check("full_at_6", 64'(lq_full), 64'd0);
         dispatch1(64'(i), (i == 0) ? 64'h40 : 64'd9, (i == 0), PW'(i)); step(); idle();
      end
      check("full_at_7", 64'(lq_full), 64'd1);
      dispatch1(64'd1, 64'd1, 1'b1, 6'd3);
      lq_mem_in2 = 1; lq_opb_valid2 = 1; step(); idle();
      check("full_ignored", 64'(lq_full), 64'd1);
      lq_mem_req_ready = 1; step(); idle();
      lq_mem_resp_valid = 1; lq_mem_resp_tag = '0; lq_mem_resp_data = 64'h55; step(); idle();
      lq_cdb_grant = 1; step(); idle();
      lq_commit = 1; step(); idle();
      check("full_after_commit", 64'(lq_full), 64'd0);
      flush_all();

      // head waiting, younger entry ready
      dispatch1(64'd0, 64'd9, 1'b0, 6'd2);
      lq_mem_in2 = 1; lq_opa_in2 = 64'h4; lq_opb_in2 = 64'h300; lq_opb_valid2 = 1;
      step(); idle();
`ifdef LQ_OOO_ISSUE_EN
      check("ooo_req_tag", 64'(lq_mem_req_tag), 64'd1);
`else
      check("ino_no_req", 64'(lq_mem_req_valid), 64'd0);
`endif
      cdb1_valid = 1; cdb1_tag = 6'd9; cdb1_in = 64'h70; step(); idle();
      check("head_ready_req", 64'(lq_mem_req_valid), 64'd1);
`ifndef LQ_OOO_ISSUE_EN
      check("ino_req_tag", 64'(lq_mem_req_tag), 64'd0);
`endif
      flush_all();

      // stalled request stays stable, then flush withdraws it
      dispatch1(64'h30, 64'h1000, 1'b1, 6'd4); step(); idle();
      a0 = lq_mem_req_addr; t0 = lq_mem_req_tag;
      check("stall_addr0", a0, 64'h1030);
      step();
      check("stall_addr1", lq_mem_req_addr, 64'h1030);
      check("stall_tag1", 64'(lq_mem_req_tag), 64'(t0));
      lq_flush = 1; step(); idle();
      check("flush_req_valid", 64'(lq_mem_req_valid), 64'd0);
      check("flush_empty", 64'(lq_empty), 64'd1);

      // wrap-around of slot tags over twelve loads
      for (int i = 0; i < 12; i++) begin
         dispatch1(64'(i), 64'h2000, 1'b1, PW'(i)); step(); idle();
         check("wrap_tag", 64'(lq_mem_req_tag), 64'(i % 8));
         check("wrap_addr", lq_mem_req_addr, 64'h2000 + 64'(i));
         lq_mem_req_ready = 1; step(); idle();
         lq_mem_resp_valid = 1; lq_mem_resp_tag = QW'(i % 8); lq_mem_resp_data = 64'(i * 3 + 1);
         step(); idle();
         check("wrap_data", lq_cdb_data, 64'(i * 3 + 1));
         lq_cdb_grant = 1; step(); idle();
         lq_commit = 1; step(); idle();
      end
      flush_all();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         drive_random();
         step();
      end
      idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/load_queue.md
LOAD_QUEUE -- requirements
Module: load_queue

Interface
REQ-001 Parameter LQ_SIZE, default 8, number of entries (power of two, >=4).
REQ-002 Parameters ROB_SIZE and PRF_SIZE, defaults `ROB_SIZE and `PRF_SIZE; set index widths RW=$clog2(ROB_SIZE)+1, PW=$clog2(PRF_SIZE), QW=$clog2(LQ_SIZE).
REQ-003 clock  in  1  single clock; all state on posedge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 lq_mem_in1/lq_mem_in2  in  1  dispatch a load in slot 1/2 this cycle.
REQ-006 lq_opa_in1/2  in  64  address offset (immediate).
REQ-007 lq_opb_in1/2  in  64  base: data if lq_opb_valid1/2=1, else PRF tag in bits [PW-1:0].
REQ-008 lq_opb_valid1/2  in  1; lq_rob_idx_in1/2  in  RW; lq_dest_idx1/2  in  PW.
REQ-009 cdb1_in/cdb2_in  in  64; cdb1_tag/cdb2_tag  in  PW; cdb1_valid/cdb2_valid  in  1.
REQ-010 lq_commit  in  1  ROB retires the head load; lq_flush  in  1  squash all entries.
REQ-011 lq_mem_req_valid out 1; lq_mem_req_addr out 64; lq_mem_req_tag out QW; lq_mem_req_ready in 1.
REQ-012 lq_mem_resp_valid in 1; lq_mem_resp_tag in QW; lq_mem_resp_data in 64.
REQ-013 lq_cdb_valid out 1; lq_cdb_data out 64; lq_cdb_tag out PW; lq_cdb_rob_idx out RW; lq_cdb_grant in 1.
REQ-014 lq_full out 1 (fewer than 2 free entries); lq_empty out 1 (no entries in use).

Function
REQ-015 Entries SHALL form a circular buffer, head/tail pointers wrap LQ_SIZE-1 -> 0; entry states FREE, WAIT_ADDR, READY, ISSUED, DONE, SENT.
REQ-016 Dispatch SHALL allocate at tail, slot 1 older than slot 2; both asserted -> two entries, tail+2; dispatch while lq_full SHALL be ignored.
REQ-017 New entry SHALL enter READY if opb_valid, else WAIT_ADDR; a CDB match in the dispatch cycle SHALL capture data and enter READY directly.
REQ-018 WAIT_ADDR entry SHALL capture cdbN_in when cdbN_valid and tag == opb[PW-1:0], entering READY next cycle; both CDBs match -> cdb1 wins.
REQ-019 Address SHALL be opa+opb, 64-bit, carry discarded.
REQ-020 Issue: at most one request per cycle; lq_mem_req_valid with addr/tag(entry index) SHALL be held stable until lq_mem_req_ready; handshake moves entry to ISSUED.
REQ-021 Response with tag of an ISSUED entry SHALL store data and move it to DONE; responses naming non-ISSUED entries SHALL be dropped.
REQ-022 Broadcast: oldest DONE entry drives lq_cdb_*; outputs held until lq_cdb_grant; grant moves entry to SENT; one broadcast per cycle.
REQ-023 lq_commit SHALL free head (-> FREE, head+1) only if head is SENT; otherwise ignored.
REQ-024 Response, grant and commit SHALL all take effect in the same cycle when they name different entries.
REQ-025 lq_flush SHALL free all entries, head=tail=0, deassert lq_mem_req_valid and lq_cdb_valid next cycle; flush overrides same-cycle dispatch/commit; system guarantees no response for flushed requests.

Reset
REQ-026 On reset low at posedge: all entries FREE, head=tail=0, lq_mem_req_valid=0, lq_cdb_valid=0, all data/tag outputs 0, lq_full=0, lq_empty=1; reset overrides all inputs, including mid-transaction.

Configuration
REQ-027 LQ_OOO_ISSUE_EN defined: oldest READY entry (search from head) SHALL issue; undefined: only the head entry may issue, and only when READY.

Verification
REQ-028 Dispatch slot1 (opa=8, opb=0x1000 valid) -> next cycle lq_mem_req_valid=1, addr=0x1008, tag=0; ready=1 -> resp data 0xAB -> lq_cdb_data=0xAB, tag=dest.
REQ-029 Dispatch opb tag 5 invalid; cdb1 and cdb2 both tag 5, data 0x10/0x20 -> addr uses 0x10.
REQ-030 Fill 7 entries of LQ_SIZE=8 -> lq_full=1; further dispatch ignored, tail unchanged; commit head after SENT -> lq_full=0.
REQ-031 Head WAIT_ADDR, entry1 READY: with LQ_OOO_ISSUE_EN tag=1 issues; without, no request until head READY.
REQ-032 Hold lq_mem_req_ready=0 3 cycles -> addr/tag stable; flush on 2nd cycle -> valid=0 next cycle, lq_empty=1.
REQ-033 Wrap: 12 dispatch/commit pairs with LQ_SIZE=8 -> tags wrap 7->0, data returned in order.
